// File: rtl/score_display_unit.sv
// Front-panel I/O for the LED-matrix flappy-bird game: flap button conditioning,
// 3-digit BCD score with seven-segment decode, and row-scanned matrix drive.
module score_display_unit #(
   parameter int SCAN_DIV = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         key_n,
   input  logic         score_inc,
   input  logic         game_over,
   input  logic [255:0] red_pixels,
   input  logic [255:0] grn_pixels,
   output logic         flap,
   output logic [11:0]  score_bcd,
   output logic [6:0]   hex0,
   output logic [6:0]   hex1,
   output logic [6:0]   hex2,
   output logic [35:0]  gpio
);

   localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic             sync1_reg, sync2_reg, sync3_reg;
   logic [3:0]       ones_reg, tens_reg, hund_reg;
   logic [3:0]       ones_next, tens_next, hund_next;
   logic [3:0]       row_reg, row_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [6:0]       seg [3];

   function automatic logic [6:0] seg7(input logic [3:0] bcd);
      case (bcd)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // key_n is asynchronous: two flops for metastability, third for edge history
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         sync3_reg <= 1'b0;
      end else begin
         sync1_reg <= ~key_n;
         sync2_reg <= sync1_reg;
         sync3_reg <= sync2_reg;
      end
   end

   assign flap = sync2_reg & ~sync3_reg;

   // Carries ripple combinationally so 099->100 and 999->000 land on one edge
   always_comb begin
      logic carry1, carry2;
      ones_next = ones_reg;
      tens_next = tens_reg;
      hund_next = hund_reg;
      carry1    = 1'b0;
      carry2    = 1'b0;
      if (score_inc && !game_over) begin
         if (ones_reg == 4'd9) begin
            ones_next = 4'd0;
            carry1    = 1'b1;
         end else begin
            ones_next = ones_reg + 4'd1;
         end
      end
      if (carry1) begin
         if (tens_reg == 4'd9) begin
            tens_next = 4'd0;
            carry2    = 1'b1;
         end else begin
            tens_next = tens_reg + 4'd1;
         end
      end
      if (carry2) begin
         hund_next = (hund_reg == 4'd9) ? 4'd0 : hund_reg + 4'd1;
      end
   end

   always_comb begin
      row_next = row_reg;
      div_next = div_reg;
      if (!game_over) begin
         if (div_reg == DIV_LAST) begin
            div_next = '0;
            row_next = row_reg + 4'd1;
         end else begin
            div_next = div_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ones_reg <= 4'd0;
         tens_reg <= 4'd0;
         hund_reg <= 4'd0;
         row_reg  <= 4'd0;
         div_reg  <= '0;
      end else begin
         ones_reg <= ones_next;
         tens_reg <= tens_next;
         hund_reg <= hund_next;
         row_reg  <= row_next;
         div_reg  <= div_next;
      end
   end

   assign score_bcd = {hund_reg, tens_reg, ones_reg};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_seg
         assign seg[gi] = seg7(score_bcd[gi*4 +: 4]);
      end
   endgenerate

   assign hex0 = seg[0];
   assign hex1 = seg[1];
   assign hex2 = seg[2];

   // Pixel data is taken from the live frame, not latched at row advance
   assign gpio = {row_reg, grn_pixels[{row_reg, 4'b0000} +: 16],
                  red_pixels[{row_reg, 4'b0000} +: 16]};

endmodule

// File: tb/tb_score_display_unit.sv
// Directed self-checking bench for score_display_unit.
module tb_score_display_unit;

   logic         clk = 1'b0;
   logic         reset;
   logic         key_n;
   logic         score_inc;
   logic         game_over;
   logic [255:0] red_pixels;
   logic [255:0] grn_pixels;
   logic         flap;
   logic [11:0]  score_bcd;
   logic [6:0]   hex0, hex1, hex2;
   logic [35:0]  gpio;

   int n_vec  = 0;
   int n_fail = 0;
   int scan_ticks = 0;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S3 = 7'b0110000,
                          S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010,
                          S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;

   score_display_unit #(.SCAN_DIV(16)) dut (
      .clk(clk), .reset(reset), .key_n(key_n), .score_inc(score_inc),
      .game_over(game_over), .red_pixels(red_pixels), .grn_pixels(grn_pixels),
      .flap(flap), .score_bcd(score_bcd), .hex0(hex0), .hex1(hex1), .hex2(hex2),
      .gpio(gpio)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; model counts edges that scan
   task automatic tick();
      @(posedge clk);
      if (!game_over && reset) scan_ticks++;
      #1;
   endtask

   function automatic logic [3:0] exp_row();
      return 4'((scan_ticks / 16) % 16);
   endfunction

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         score_inc = 1'b1;
         tick();
      end
      score_inc = 1'b0;
   endtask

   initial begin
      int cnt;
      logic [3:0] held_row;
      reset = 1'b0; key_n = 1'b1; score_inc = 1'b0; game_over = 1'b0;
      red_pixels = '0; grn_pixels = '0;
      red_pixels[3*16+5]  = 1'b1;
      grn_pixels[3*16+15] = 1'b1;
      #1;
      tick(); tick();
      check("rst_flap", {39'd0, flap}, 40'd0);
      check("rst_score", {28'd0, score_bcd}, 40'd0);
      check("rst_hex", {19'd0, hex2, hex1, hex0}, {19'd0, S0, S0, S0});
      check("rst_gpio", {4'd0, gpio}, 40'd0);

      reset = 1'b1; scan_ticks = 0;
      for (int i = 0; i < 15; i++) tick();
      check("row_after15", {36'd0, gpio[35:32]}, 40'd0);
      tick();
      check("row_after16", {36'd0, gpio[35:32]}, 40'd1);
      for (int i = 16; i < 256; i++) tick();
      check("row_after256", {36'd0, gpio[35:32]}, 40'd0);

      for (int i = 0; i < 48; i++) tick();
      check("pix_row3", {4'd0, gpio}, {4'd0, 4'd3, 16'h8000, 16'h0020});
      for (int i = 0; i < 16; i++) tick();
      check("pix_row4", {4'd0, gpio}, {4'd0, 4'd4, 32'd0});

      key_n = 1'b0;
      tick();
      check("flap_k", {39'd0, flap}, 40'd0);
      tick();
      check("flap_k1", {39'd0, flap}, 40'd1);
      tick();
      check("flap_k2", {39'd0, flap}, 40'd0);
      cnt = 0;
      for (int i = 0; i < 47; i++) begin tick(); cnt += int'(flap); end
      check("flap_hold", cnt, 0);
      key_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      key_n = 1'b0;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin tick(); cnt += int'(flap); end
      check("flap_repress", cnt, 1);
      key_n = 1'b1;

      game_over = 1'b1;
      held_row = gpio[35:32];
      check("freeze_row_model", {36'd0, held_row}, {36'd0, exp_row()});
      for (int i = 0; i < 40; i++) begin
         score_inc = 1'b1;
         tick();
      end
      score_inc = 1'b0;
      check("freeze_score", {28'd0, score_bcd}, 40'd0);
      check("freeze_row", {36'd0, gpio[35:32]}, {36'd0, held_row});
      game_over = 1'b0;
      cnt = 16 - (scan_ticks % 16);
      for (int i = 0; i < cnt - 1; i++) tick();
      check("resume_before", {36'd0, gpio[35:32]}, {36'd0, held_row});
      tick();
      check("resume_adv", {36'd0, gpio[35:32]}, {36'd0, held_row + 4'd1});

      for (int i = 0; i < 99; i++) begin
         score_inc = 1'b1; tick();
         score_inc = 1'b0; tick();
      end
      check("score_099", {28'd0, score_bcd}, 40'h099);
      check("hex_099", {19'd0, hex2, hex1, hex0}, {19'd0, S0, S9, S9});
      pulses(1);
      check("score_100", {28'd0, score_bcd}, 40'h100);
      check("hex_100", {19'd0, hex2, hex1, hex0}, {19'd0, S1, S0, S0});
      pulses(245);
      check("score_345", {28'd0, score_bcd}, 40'h345);
      check("hex_345", {19'd0, hex2, hex1, hex0}, {19'd0, S3, S4, S5});
      pulses(333);
      check("hex_678", {19'd0, hex2, hex1, hex0}, {19'd0, S6, S7, S8});
      pulses(321);
      check("score_999", {28'd0, score_bcd}, 40'h999);
      game_over = 1'b1; score_inc = 1'b1;
      tick();
      game_over = 1'b0; score_inc = 1'b0;
      check("inc_gameover", {28'd0, score_bcd}, 40'h999);
      pulses(1);
      check("score_wrap", {28'd0, score_bcd}, 40'h000);

      pulses(57);
      cnt = 0;
      while (exp_row() != 4'd9 && cnt < 300) begin tick(); cnt++; end
      check("pre_rst_score", {28'd0, score_bcd}, 40'h057);
      check("pre_rst_hex", {26'd0, hex1, hex0}, {26'd0, S5, S7});
      check("pre_rst_row", {36'd0, gpio[35:32]}, 40'd9);
      #2 reset = 1'b0;
      #2;
      check("async_score", {28'd0, score_bcd}, 40'd0);
      check("async_hex", {19'd0, hex2, hex1, hex0}, {19'd0, S0, S0, S0});
      check("async_gpio", {4'd0, gpio}, 40'd0);
      check("async_flap", {39'd0, flap}, 40'd0);
      tick();
      reset = 1'b1; scan_ticks = 0;
      pulses(1);
      check("post_rst_count", {28'd0, score_bcd}, 40'h001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
